// File: rtl/sccb_cfg_sequencer.sv
// Sensor configuration sequencer: walks a {reg_addr, reg_value} ROM at boot,
// honours millisecond delay entries, then serves runtime register writes,
// driving one SCCB write transaction at a time.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | after reset, waiting for cfg_start
// FETCH     | rom_addr presented, ROM word arrives next cycle
// DECODE    | classify ROM word: end marker, delay entry or register write
// DELAY     | down-counting a delay entry
// ISSUE     | waiting for sccb_ready, then strobing sccb_start
// WAIT_DONE | transaction in flight, watchdog running
// READY     | boot finished, serving runtime writes
// ERROR     | SCCB master never answered, waiting for cfg_start
module sccb_cfg_sequencer #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned ROM_AW      = 6,
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              usr_req,
  input  logic [7:0]        usr_addr,
  input  logic [7:0]        usr_data,
  output logic              usr_ack,
  output logic              sccb_start,
  output logic [7:0]        sccb_reg_addr,
  output logic [7:0]        sccb_reg_data,
  input  logic              sccb_ready,
  input  logic              sccb_done,
  output logic              busy,
  output logic              config_done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_DELAY, S_ISSUE, S_WAIT_DONE, S_READY, S_ERROR
  } state_t;

  localparam logic [31:0]       MS_CYC    = 32'(CLK_FREQ / 1000);
  localparam logic [31:0]       TO_LOAD   = 32'(TIMEOUT_CYC - 1);
  localparam logic [ROM_AW-1:0] ADDR_LAST = '1;
  localparam logic [ROM_AW-1:0] ADDR_ONE  = {{(ROM_AW-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ROM_AW-1:0] r_rom_addr;
  logic [31:0]       r_delay_cnt;
  logic [31:0]       r_to_cnt;
  logic              r_is_user;
  logic              r_usr_ack;
  logic              r_sccb_start;
  logic [7:0]        r_reg_addr;
  logic [7:0]        r_reg_data;
  logic              r_busy;
  logic              r_config_done;
  logic              r_err;

  logic [31:0] w_delay_cyc;
  logic        w_is_end;
  logic        w_is_delay;
  logic        w_addr_last;
  logic        w_cfg_go;
  logic        w_advance;

  assign w_delay_cyc = {24'd0, rom_data[7:0]} * MS_CYC;
  assign w_is_end    = (rom_data == 16'hFFFF);
  assign w_is_delay  = (rom_data[15:8] == 8'hF0);
  assign w_addr_last = (r_rom_addr == ADDR_LAST);

  // cfg_start is only honoured where no boot or transaction is in flight
  assign w_cfg_go = cfg_start &&
                    ((r_state == S_IDLE) || (r_state == S_READY) || (r_state == S_ERROR));

  // every way a boot entry can finish: zero delay, expired delay, boot write done
  assign w_advance = ((r_state == S_DECODE) && !w_is_end && w_is_delay && (w_delay_cyc == 32'd0))
                  || ((r_state == S_DELAY) && (r_delay_cnt == 32'd0))
                  || ((r_state == S_WAIT_DONE) && sccb_done && !r_is_user);

  // sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rom_addr    <= '0;
      r_delay_cnt   <= '0;
      r_to_cnt      <= '0;
      r_is_user     <= 1'b0;
      r_usr_ack     <= 1'b0;
      r_sccb_start  <= 1'b0;
      r_reg_addr    <= '0;
      r_reg_data    <= '0;
      r_busy        <= 1'b0;
      r_config_done <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_sccb_start <= 1'b0;
      r_usr_ack    <= 1'b0;
      if (w_cfg_go) begin
        r_state       <= S_FETCH;
        r_rom_addr    <= '0;
        r_is_user     <= 1'b0;
        r_busy        <= 1'b1;
        r_config_done <= 1'b0;
        r_err         <= 1'b0;
      end else if (w_advance) begin
        // last ROM slot behaves as an implicit end marker, no wrap to 0
        if (w_addr_last) begin
          r_state       <= S_READY;
          r_busy        <= 1'b0;
          r_config_done <= 1'b1;
        end else begin
          r_rom_addr <= r_rom_addr + ADDR_ONE;
          r_state    <= S_FETCH;
        end
      end else begin
        case (r_state)
          S_FETCH: r_state <= S_DECODE;
          S_DECODE: begin
            if (w_is_end) begin
              r_state       <= S_READY;
              r_busy        <= 1'b0;
              r_config_done <= 1'b1;
            end else if (w_is_delay) begin
              r_delay_cnt <= w_delay_cyc - 32'd1;
              r_state     <= S_DELAY;
            end else begin
              r_reg_addr <= rom_data[15:8];
              r_reg_data <= rom_data[7:0];
              r_state    <= S_ISSUE;
            end
          end
          S_DELAY: r_delay_cnt <= r_delay_cnt - 32'd1;
          S_ISSUE: begin
            if (sccb_ready) begin
              r_sccb_start <= 1'b1;
              r_to_cnt     <= TO_LOAD;
              r_state      <= S_WAIT_DONE;
            end
          end
          S_WAIT_DONE: begin
            // boot completions are taken by w_advance, so done here is a user write
            if (sccb_done) begin
              r_usr_ack <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_READY;
            end else if (r_to_cnt == 32'd0) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_ERROR;
            end else begin
              r_to_cnt <= r_to_cnt - 32'd1;
            end
          end
          S_READY: begin
            // usr_req is still high in the ack cycle; do not start a second write
            if (usr_req && !r_usr_ack) begin
              r_reg_addr <= usr_addr;
              r_reg_data <= usr_data;
              r_is_user  <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_ISSUE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rom_addr      = r_rom_addr;
  assign usr_ack       = r_usr_ack;
  assign sccb_start    = r_sccb_start;
  assign sccb_reg_addr = r_reg_addr;
  assign sccb_reg_data = r_reg_data;
  assign busy          = r_busy;
  assign config_done   = r_config_done;
  assign err           = r_err;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench for sccb_cfg_sequencer: instance A (default clock, 6-bit ROM, short
// watchdog) and instance S (2-bit ROM, 10 cycles per ms) against a ROM model,
// an SCCB master responder and a list-walking boot model.
`timescale 1ns/1ps
module tb_sccb_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int n_overlap = 0;

  // instance A
  logic        rst_a, cfg_start_a, usr_req_a, usr_ack_a, sccb_start_a;
  logic [5:0]  rom_addr_a;
  logic [15:0] rom_data_a;
  logic [7:0]  usr_addr_a, usr_data_a, sccb_reg_addr_a, sccb_reg_data_a;
  logic        sccb_ready_a, sccb_done_a, busy_a, config_done_a, err_a;
  logic [15:0] rom_a [64];
  int          lat_a;
  bit          hold_a;
  logic [15:0] wr_q_a[$];
  int unsigned st_cyc_a[$];

  // instance S
  logic        rst_s, cfg_start_s, usr_req_s, usr_ack_s, sccb_start_s;
  logic [1:0]  rom_addr_s;
  logic [15:0] rom_data_s;
  logic [7:0]  usr_addr_s, usr_data_s, sccb_reg_addr_s, sccb_reg_data_s;
  logic        sccb_ready_s, sccb_done_s, busy_s, config_done_s, err_s;
  logic [15:0] rom_s [4];
  int          lat_s;
  bit          hold_s;
  logic [15:0] wr_q_s[$];

  logic [15:0] exp_q[$];
  int          exp_last;

  sccb_cfg_sequencer #(.CLK_FREQ(50_000_000), .ROM_AW(6), .TIMEOUT_CYC(1000)) u_dut_a (
    .clk(clk), .rst(rst_a), .cfg_start(cfg_start_a), .rom_addr(rom_addr_a),
    .rom_data(rom_data_a), .usr_req(usr_req_a), .usr_addr(usr_addr_a),
    .usr_data(usr_data_a), .usr_ack(usr_ack_a), .sccb_start(sccb_start_a),
    .sccb_reg_addr(sccb_reg_addr_a), .sccb_reg_data(sccb_reg_data_a),
    .sccb_ready(sccb_ready_a), .sccb_done(sccb_done_a), .busy(busy_a),
    .config_done(config_done_a), .err(err_a));

  sccb_cfg_sequencer #(.CLK_FREQ(10_000), .ROM_AW(2), .TIMEOUT_CYC(1000)) u_dut_s (
    .clk(clk), .rst(rst_s), .cfg_start(cfg_start_s), .rom_addr(rom_addr_s),
    .rom_data(rom_data_s), .usr_req(usr_req_s), .usr_addr(usr_addr_s),
    .usr_data(usr_data_s), .usr_ack(usr_ack_s), .sccb_start(sccb_start_s),
    .sccb_reg_addr(sccb_reg_addr_s), .sccb_reg_data(sccb_reg_data_s),
    .sccb_ready(sccb_ready_s), .sccb_done(sccb_done_s), .busy(busy_s),
    .config_done(config_done_s), .err(err_s));

  // synchronous ROMs: data valid one cycle after the address
  always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];
  always @(posedge clk) rom_data_s <= rom_s[rom_addr_s];

  always @(negedge clk)
    if ((usr_ack_a && sccb_start_a) || (usr_ack_s && sccb_start_s)) n_overlap++;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wr_at_a(input int i);
    return (i < wr_q_a.size()) ? 32'(wr_q_a[i]) : 32'hBAD0BAD0;
  endfunction

  function automatic logic [31:0] wr_at_s(input int i);
    return (i < wr_q_s.size()) ? 32'(wr_q_s[i]) : 32'hBAD0BAD0;
  endfunction

  // SCCB master model A: records each write, answers after lat_a cycles unless held
  initial begin
    logic [15:0] w;
    sccb_done_a = 1'b0;
    sccb_ready_a = 1'b1;
    forever begin
      @(negedge clk);
      if (sccb_start_a) begin
        w = {sccb_reg_addr_a, sccb_reg_data_a};
        wr_q_a.push_back(w);
        st_cyc_a.push_back(cyc);
        sccb_ready_a = 1'b0;
        if (hold_a) begin
          while (hold_a) @(negedge clk);
        end else begin
          repeat (lat_a) @(negedge clk);
          chk_eq("reg_stable_a", 32'({sccb_reg_addr_a, sccb_reg_data_a}), 32'(w));
          sccb_done_a = 1'b1;
          @(negedge clk);
          sccb_done_a = 1'b0;
        end
        sccb_ready_a = 1'b1;
      end
    end
  end

  // SCCB master model S
  initial begin
    logic [15:0] w;
    sccb_done_s = 1'b0;
    sccb_ready_s = 1'b1;
    forever begin
      @(negedge clk);
      if (sccb_start_s) begin
        w = {sccb_reg_addr_s, sccb_reg_data_s};
        wr_q_s.push_back(w);
        sccb_ready_s = 1'b0;
        if (hold_s) begin
          while (hold_s) @(negedge clk);
        end else begin
          repeat (lat_s) @(negedge clk);
          chk_eq("reg_stable_s", 32'({sccb_reg_addr_s, sccb_reg_data_s}), 32'(w));
          sccb_done_s = 1'b1;
          @(negedge clk);
          sccb_done_s = 1'b0;
        end
        sccb_ready_s = 1'b1;
      end
    end
  end

  // boot model: walk entries in order, writes are every non-delay word before the end
  task automatic model_boot_s();
    exp_q.delete();
    exp_last = 3;
    for (int a = 0; a < 4; a++) begin
      if (rom_s[a] == 16'hFFFF) begin
        exp_last = a;
        break;
      end
      if (rom_s[a][15:8] != 8'hF0) exp_q.push_back(rom_s[a]);
    end
  endtask

  function automatic logic [15:0] rand_word();
    int unsigned k;
    logic [15:0] w;
    k = $urandom_range(0, 7);
    if (k == 0) w = 16'hFFFF;
    else if (k <= 2) w = {8'hF0, 8'($urandom_range(0, 3))};
    else begin
      w = 16'($urandom);
      if (w[15:8] == 8'hF0 || w[15:8] == 8'hFF) w[15:8] = 8'h21;
    end
    return w;
  endfunction

  task automatic wait_ready_a(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (config_done_a && !busy_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ready_s(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (config_done_s && !busy_s) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ack_a(input int lim, output bit ok, output int unsigned t);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (usr_ack_a) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  task automatic pulse_cfg_a();
    @(negedge clk);
    cfg_start_a = 1'b1;
    @(negedge clk);
    cfg_start_a = 1'b0;
  endtask

  task automatic pulse_cfg_s();
    @(negedge clk);
    cfg_start_s = 1'b1;
    @(negedge clk);
    cfg_start_s = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: run did not end, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit early;
    int unsigned t1, gap;
    int cnt;
    logic [7:0] ua, ud;

    rst_a = 1'b1; rst_s = 1'b1;
    cfg_start_a = 1'b0; cfg_start_s = 1'b0;
    usr_req_a = 1'b0; usr_req_s = 1'b0;
    usr_addr_a = '0; usr_data_a = '0; usr_addr_s = '0; usr_data_s = '0;
    hold_a = 1'b0; hold_s = 1'b0;
    lat_a = 8; lat_s = 5;
    for (int i = 0; i < 64; i++) rom_a[i] = 16'hFFFF;
    rom_a[0] = 16'h1280; rom_a[1] = 16'hF001; rom_a[2] = 16'h40D0; rom_a[3] = 16'hFFFF;
    rom_s[0] = 16'h0102; rom_s[1] = 16'h0304; rom_s[2] = 16'h0506; rom_s[3] = 16'h0708;

    repeat (3) @(negedge clk);
    chk_eq("rst_outs_a", 32'({rom_addr_a, usr_ack_a, sccb_start_a, sccb_reg_addr_a,
                              sccb_reg_data_a, busy_a, config_done_a, err_a}), 32'd0);
    chk_eq("rst_outs_s", 32'({rom_addr_s, usr_ack_s, sccb_start_s, sccb_reg_addr_s,
                              sccb_reg_data_s, busy_s, config_done_s, err_s}), 32'd0);
    rst_a = 1'b0; rst_s = 1'b0;

    // usr_req before any boot must be ignored
    usr_req_s = 1'b1; usr_addr_s = 8'h5A; usr_data_s = 8'hC3;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (usr_ack_s || sccb_start_s || busy_s) cnt++;
    end
    usr_req_s = 1'b0;
    chk_eq("idle_usr_ignored", 32'(cnt), 32'd0);

    // boot A with a 1 ms delay between the two writes
    pulse_cfg_a();
    wait_ready_a(60000, ok);
    chk_eq("boot_a_reached", 32'(ok), 32'd1);
    chk_eq("boot_a_nwr", 32'(wr_q_a.size()), 32'd2);
    chk_eq("boot_a_wr0", wr_at_a(0), 32'h1280);
    chk_eq("boot_a_wr1", wr_at_a(1), 32'h40D0);
    gap = (st_cyc_a.size() == 2) ? st_cyc_a[1] - st_cyc_a[0] : 0;
    chk_eq("boot_a_gap_min", 32'(gap >= 32'(50_000 + lat_a)), 32'd1);
    chk_eq("boot_a_gap_max", 32'(gap <= 32'(50_000 + lat_a + 12)), 32'd1);
    chk_eq("boot_a_status", 32'({config_done_a, busy_a, err_a}), 32'b100);
    chk_eq("boot_a_rom_addr", 32'(rom_addr_a), 32'd3);

    // runtime write with done 100 cycles after start
    lat_a = 100;
    wr_q_a.delete(); st_cyc_a.delete();
    @(negedge clk);
    usr_addr_a = 8'h3E; usr_data_a = 8'h19; usr_req_a = 1'b1;
    wait_ack_a(1000, ok, t1);
    usr_req_a = 1'b0;
    chk_eq("usr_ack_seen", 32'(ok), 32'd1);
    chk_eq("usr_ack_lat", (st_cyc_a.size() > 0) ? 32'(t1 - st_cyc_a[0]) : 32'hFFFFFFFF, 32'd101);
    @(negedge clk);
    chk_eq("usr_ack_pulse", 32'(usr_ack_a), 32'd0);
    repeat (10) @(negedge clk);
    chk_eq("usr_nwr", 32'(wr_q_a.size()), 32'd1);
    chk_eq("usr_wr", wr_at_a(0), 32'h3E19);
    chk_eq("usr_status", 32'({config_done_a, busy_a}), 32'b10);

    // randomized runtime writes
    for (int k = 0; k < 6; k++) begin
      lat_a = $urandom_range(1, 40);
      ua = 8'($urandom); ud = 8'($urandom);
      wr_q_a.delete(); st_cyc_a.delete();
      @(negedge clk);
      usr_addr_a = ua; usr_data_a = ud; usr_req_a = 1'b1;
      wait_ack_a(500, ok, t1);
      usr_req_a = 1'b0;
      chk_eq($sformatf("rnd_usr%0d_ack", k), 32'(ok), 32'd1);
      chk_eq($sformatf("rnd_usr%0d_wr", k), wr_at_a(0), 32'({ua, ud}));
      chk_eq($sformatf("rnd_usr%0d_lat", k),
             (st_cyc_a.size() > 0) ? 32'(t1 - st_cyc_a[0]) : 32'hFFFFFFFF, 32'(lat_a + 1));
      repeat (3) @(negedge clk);
      chk_eq($sformatf("rnd_usr%0d_nwr", k), 32'(wr_q_a.size()), 32'd1);
    end

    // cfg_start and usr_req together: boot first, write after
    rom_a[1] = 16'h40D0; rom_a[2] = 16'hFFFF;
    lat_a = 6;
    wr_q_a.delete(); st_cyc_a.delete();
    @(negedge clk);
    cfg_start_a = 1'b1; usr_req_a = 1'b1; usr_addr_a = 8'h55; usr_data_a = 8'hAA;
    @(negedge clk);
    cfg_start_a = 1'b0;
    chk_eq("both_done_cleared", 32'(config_done_a), 32'd0);
    ok = 1'b0; early = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (usr_ack_a) begin
        ok = 1'b1;
        if (!config_done_a) early = 1'b1;
        break;
      end
    end
    usr_req_a = 1'b0;
    chk_eq("both_ack_seen", 32'(ok), 32'd1);
    chk_eq("both_ack_after_done", 32'(early), 32'd0);
    chk_eq("both_nwr", 32'(wr_q_a.size()), 32'd3);
    chk_eq("both_wr0", wr_at_a(0), 32'h1280);
    chk_eq("both_wr1", wr_at_a(1), 32'h40D0);
    chk_eq("both_wr2", wr_at_a(2), 32'h55AA);

    // watchdog: withhold sccb_done
    hold_a = 1'b1;
    wr_q_a.delete(); st_cyc_a.delete();
    @(negedge clk);
    usr_addr_a = 8'h77; usr_data_a = 8'h88; usr_req_a = 1'b1;
    ok = 1'b0; t1 = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (err_a) begin ok = 1'b1; t1 = cyc; break; end
    end
    usr_req_a = 1'b0;
    chk_eq("to_err_seen", 32'(ok), 32'd1);
    chk_eq("to_err_lat", (st_cyc_a.size() > 0) ? 32'(t1 - st_cyc_a[0]) : 32'hFFFFFFFF, 32'd1000);
    chk_eq("to_busy", 32'(busy_a), 32'd0);
    repeat (5) @(negedge clk);
    chk_eq("to_err_sticky", 32'({err_a, usr_ack_a}), 32'b10);
    hold_a = 1'b0;
    pulse_cfg_a();
    chk_eq("to_restart", 32'({err_a, busy_a, rom_addr_a}), 32'({1'b0, 1'b1, 6'd0}));
    wait_ready_a(2000, ok);
    chk_eq("to_reboot_done", 32'(ok), 32'd1);
    chk_eq("to_reboot_nwr", 32'(wr_q_a.size()), 32'd3);
    chk_eq("to_reboot_wr1", wr_at_a(1), 32'h1280);
    chk_eq("to_reboot_wr2", wr_at_a(2), 32'h40D0);

    // S: no end marker, 2-bit ROM
    pulse_cfg_s();
    wait_ready_s(500, ok);
    chk_eq("noend_done", 32'(ok), 32'd1);
    chk_eq("noend_nwr", 32'(wr_q_s.size()), 32'd4);
    chk_eq("noend_wr3", wr_at_s(3), 32'h0708);
    chk_eq("noend_rom_addr", 32'(rom_addr_s), 32'd3);
    repeat (10) @(negedge clk);
    chk_eq("noend_no_wrap", 32'({rom_addr_s, busy_s, 3'(wr_q_s.size())}), 32'({2'd3, 1'b0, 3'd4}));

    // S: randomized ROM contents with a stray cfg_start while busy
    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < 4; j++) rom_s[j] = rand_word();
      model_boot_s();
      lat_s = $urandom_range(1, 12);
      wr_q_s.delete();
      pulse_cfg_s();
      if (busy_s) begin
        cfg_start_s = 1'b1;
        @(negedge clk);
        cfg_start_s = 1'b0;
      end
      wait_ready_s(2000, ok);
      chk_eq($sformatf("rnd_boot%0d_done", it), 32'(ok), 32'd1);
      chk_eq($sformatf("rnd_boot%0d_nwr", it), 32'(wr_q_s.size()), 32'(exp_q.size()));
      for (int j = 0; j < exp_q.size(); j++)
        chk_eq($sformatf("rnd_boot%0d_wr%0d", it, j), wr_at_s(j), 32'(exp_q[j]));
      chk_eq($sformatf("rnd_boot%0d_addr", it), 32'(rom_addr_s), 32'(exp_last));
    end

    // S: reset in the middle of a transaction
    rom_s[0] = 16'h0102; rom_s[1] = 16'h0304; rom_s[2] = 16'h0506; rom_s[3] = 16'h0708;
    hold_s = 1'b1;
    wr_q_s.delete();
    pulse_cfg_s();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (wr_q_s.size() > 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk_eq("midrst_in_flight", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    rst_s = 1'b1;
    @(negedge clk);
    chk_eq("midrst_outs", 32'({rom_addr_s, usr_ack_s, sccb_start_s, sccb_reg_addr_s,
                               sccb_reg_data_s, busy_s, config_done_s, err_s}), 32'd0);
    rst_s = 1'b0;
    hold_s = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sccb_start_s || busy_s || config_done_s) cnt++;
    end
    chk_eq("midrst_stays_idle", 32'(cnt), 32'd0);

    chk_eq("ack_start_overlap", 32'(n_overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
